// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
//
// Shares one asynchronous 16-bit external SRAM between the SPI slave path
// ("slave" port) and the Si4463 wireless path ("master" port). Each granted
// request runs one complete read or write cycle. All SRAM pins are registered.
//
// Ports (one identical set per requester, prefix slave_ / master_):
//   p_req      in   request level, held until p_done
//   p_we       in   1 = write, 0 = read
//   p_addr     in   18-bit word address
//   p_be       in   byte enables, [1] upper, [0] lower, active-high
//   p_wdata    in   write data
//   p_grant    out  high for the whole access owned by this port
//   p_done     out  one-cycle pulse at end of access
//   p_rdata    out  read data, valid with p_done, held until next read
// SRAM side:
//   mem_addr   out  SRAM address
//   dout_o     out  write data toward the pad
//   dout_i     in   data from the pad
//   dout_oe    out  pad output enable
//   CE_n, OE_n, WE_n, LB_n, UB_n  out  active-low SRAM controls
//
// Build option: define ARB_MASTER_PRIORITY_EN to make the master port win on
// contention, with a burst counter that forces a pending slave request
// through after MAX_BURST consecutive master grants. Otherwise contention is
// resolved round-robin.
// ---------------------------------------------------------------------------
module sram_port_arbiter #(
    parameter int ACCESS_CYCLES = 4,
    parameter int MAX_BURST     = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        slave_req,
    input  logic        slave_we,
    input  logic [17:0] slave_addr,
    input  logic [1:0]  slave_be,
    input  logic [15:0] slave_wdata,
    output logic        slave_grant,
    output logic        slave_done,
    output logic [15:0] slave_rdata,

    input  logic        master_req,
    input  logic        master_we,
    input  logic [17:0] master_addr,
    input  logic [1:0]  master_be,
    input  logic [15:0] master_wdata,
    output logic        master_grant,
    output logic        master_done,
    output logic [15:0] master_rdata,

    output logic [17:0] mem_addr,
    output logic [15:0] dout_o,
    input  logic [15:0] dout_i,
    output logic        dout_oe,
    output logic        CE_n,
    output logic        OE_n,
    output logic        WE_n,
    output logic        LB_n,
    output logic        UB_n
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] LAST_CNT   = 4'(ACCESS_CYCLES - 1);
    localparam logic [3:0] WE_END_CNT = 4'(ACCESS_CYCLES - 2);

    // Reject illegal configurations at elaboration time.
    generate
        if (ACCESS_CYCLES < 2 || ACCESS_CYCLES > 15 || MAX_BURST < 1 || MAX_BURST > 255) begin : gBadParams
            $error("sram_port_arbiter: ACCESS_CYCLES or MAX_BURST out of range");
        end
    endgenerate

    state_t      state_q;
    logic [3:0]  cycleCnt_q;
    logic        we_q;
    logic        pickMaster_d;
    logic        selWe_d;
    logic [17:0] selAddr_d;
    logic [1:0]  selBe_d;
    logic [15:0] selWdata_d;

`ifdef ARB_MASTER_PRIORITY_EN
    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

    logic [7:0] burstCnt_q;

    // Master wins contention unless it has already taken MAX_BURST grants in
    // a row while the slave was waiting.
    always_comb begin
        pickMaster_d = master_req;
        if (master_req && slave_req && (burstCnt_q >= BURST_LIMIT)) begin
            pickMaster_d = 1'b0;
        end
    end

    // Counts master grants taken while the slave was kept waiting; any slave
    // grant or slave-idle IDLE cycle starts the count over.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burstCnt_q <= 8'd0;
        end else if (state_q == IDLE) begin
            if (!slave_req) begin
                burstCnt_q <= 8'd0;
            end else if (pickMaster_d) begin
                burstCnt_q <= burstCnt_q + 8'd1;
            end else begin
                burstCnt_q <= 8'd0;
            end
        end
    end
`else
    logic lastOwner_q;  // 1 = master owned the previous access

    // On contention the port that did not own the previous access wins.
    always_comb begin
        pickMaster_d = master_req && (!slave_req || !lastOwner_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lastOwner_q <= 1'b1;
        end else if (state_q == IDLE && (slave_req || master_req)) begin
            lastOwner_q <= pickMaster_d;
        end
    end
`endif

    // Request fields of whichever port wins this IDLE cycle.
    always_comb begin
        selWe_d    = slave_we;
        selAddr_d  = slave_addr;
        selBe_d    = slave_be;
        selWdata_d = slave_wdata;
        if (pickMaster_d) begin
            selWe_d    = master_we;
            selAddr_d  = master_addr;
            selBe_d    = master_be;
            selWdata_d = master_wdata;
        end
    end

    // Access sequencer. Address, byte enables and write data are captured
    // straight into the pin registers at grant time, so they stay frozen for
    // the whole access regardless of what the requester does afterwards.
    // WE_n releases one count early to give data-hold margin before CE_n rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cycleCnt_q   <= 4'd0;
            we_q         <= 1'b0;
            slave_grant  <= 1'b0;
            master_grant <= 1'b0;
            slave_done   <= 1'b0;
            master_done  <= 1'b0;
            slave_rdata  <= 16'd0;
            master_rdata <= 16'd0;
            mem_addr     <= 18'd0;
            dout_o       <= 16'd0;
            dout_oe      <= 1'b0;
            CE_n         <= 1'b1;
            OE_n         <= 1'b1;
            WE_n         <= 1'b1;
            LB_n         <= 1'b1;
            UB_n         <= 1'b1;
        end else begin
            slave_done  <= 1'b0;
            master_done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (slave_req || master_req) begin
                        slave_grant  <= !pickMaster_d;
                        master_grant <= pickMaster_d;
                        we_q         <= selWe_d;
                        mem_addr     <= selAddr_d;
                        LB_n         <= ~selBe_d[0];
                        UB_n         <= ~selBe_d[1];
                        CE_n         <= 1'b0;
                        OE_n         <= selWe_d;
                        WE_n         <= ~selWe_d;
                        dout_oe      <= selWe_d;
                        if (selWe_d) begin
                            dout_o <= selWdata_d;
                        end
                        cycleCnt_q   <= 4'd0;
                        state_q      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cycleCnt_q == LAST_CNT) begin
                        if (!we_q) begin
                            if (master_grant) begin
                                master_rdata <= dout_i;
                            end else begin
                                slave_rdata <= dout_i;
                            end
                        end
                        master_done <= master_grant;
                        slave_done  <= slave_grant;
                        CE_n        <= 1'b1;
                        OE_n        <= 1'b1;
                        WE_n        <= 1'b1;
                        LB_n        <= 1'b1;
                        UB_n        <= 1'b1;
                        dout_oe     <= 1'b0;
                        state_q     <= DONE;
                    end else begin
                        if (cycleCnt_q == WE_END_CNT) begin
                            WE_n <= 1'b1;
                        end
                        cycleCnt_q <= cycleCnt_q + 4'd1;
                    end
                end
                DONE: begin
                    slave_grant  <= 1'b0;
                    master_grant <= 1'b0;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_port_arbiter
//
// Self-checking bench for sram_port_arbiter. A behavioural SRAM answers on
// dout_i, expected completions are queued when requests are raised and
// popped as done pulses arrive. Works for both the round-robin build and
// the ARB_MASTER_PRIORITY_EN build (MAX_BURST = 3).
// ---------------------------------------------------------------------------
module tb_sram_port_arbiter;

    localparam int ACCESS_CYCLES = 4;
    localparam int MAX_BURST     = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        slave_req, slave_we, master_req, master_we;
    logic [17:0] slave_addr, master_addr;
    logic [1:0]  slave_be, master_be;
    logic [15:0] slave_wdata, master_wdata;
    logic        slave_grant, slave_done, master_grant, master_done;
    logic [15:0] slave_rdata, master_rdata;
    logic [17:0] mem_addr;
    logic [15:0] dout_o;
    logic [15:0] dout_i = 16'hDEAD;
    logic        dout_oe, CE_n, OE_n, WE_n, LB_n, UB_n;

    typedef struct packed {
        logic        port;   // 1 = master
        logic        we;
        logic [15:0] rdata;
    } expEntry_t;

    expEntry_t   sbQueue[$];
    int          testCount = 0;
    int          failCount = 0;
    logic [15:0] sramModel [logic [17:0]];
    logic [15:0] modelWord;

    sram_port_arbiter #(
        .ACCESS_CYCLES(ACCESS_CYCLES),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .reset(reset),
        .slave_req(slave_req), .slave_we(slave_we), .slave_addr(slave_addr),
        .slave_be(slave_be), .slave_wdata(slave_wdata),
        .slave_grant(slave_grant), .slave_done(slave_done), .slave_rdata(slave_rdata),
        .master_req(master_req), .master_we(master_we), .master_addr(master_addr),
        .master_be(master_be), .master_wdata(master_wdata),
        .master_grant(master_grant), .master_done(master_done), .master_rdata(master_rdata),
        .mem_addr(mem_addr), .dout_o(dout_o), .dout_i(dout_i), .dout_oe(dout_oe),
        .CE_n(CE_n), .OE_n(OE_n), .WE_n(WE_n), .LB_n(LB_n), .UB_n(UB_n)
    );

    always #5 clk = ~clk;

    // Counts every comparison and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Queues the expected completion and raises the request on one port.
    task automatic applyStimulus(input logic port, input logic we, input logic [17:0] addr,
                                 input logic [1:0] be, input logic [15:0] wdata,
                                 input logic [15:0] expRdata);
        expEntry_t e;
        e.port  = port;
        e.we    = we;
        e.rdata = expRdata;
        sbQueue.push_back(e);
        if (port) begin
            master_we = we; master_addr = addr; master_be = be; master_wdata = wdata;
            master_req = 1'b1;
        end else begin
            slave_we = we; slave_addr = addr; slave_be = be; slave_wdata = wdata;
            slave_req = 1'b1;
        end
    endtask

    // Waits (bounded) for this port's done pulse, then drops its request.
    task automatic waitDone(input logic port, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!(port ? master_done : slave_done) && waited < 50);
        if (!(port ? master_done : slave_done)) checkOutput("doneTimeout", 32'd0, 32'd1);
        if (port) master_req = 1'b0; else slave_req = 1'b0;
    endtask

    // Behavioural SRAM: byte-masked writes while CE_n/WE_n are low, read data
    // only while CE_n/OE_n are low, otherwise a recognisable junk value.
    always @(negedge clk) begin
        if (!CE_n && !WE_n && dout_oe) begin
            modelWord = sramModel.exists(mem_addr) ? sramModel[mem_addr] : 16'h0000;
            if (!LB_n) modelWord[7:0]  = dout_o[7:0];
            if (!UB_n) modelWord[15:8] = dout_o[15:8];
            sramModel[mem_addr] = modelWord;
        end
        if (!CE_n && !OE_n) begin
            dout_i = sramModel.exists(mem_addr) ? sramModel[mem_addr] : 16'h0000;
        end else begin
            dout_i = 16'hDEAD;
        end
    end

    // Scoreboard: every done pulse must match the next expected completion.
    always @(negedge clk) begin
        expEntry_t e;
        if (!reset) begin
            if (slave_grant || master_grant) checkOutput("grantOneHot", 32'(slave_grant & master_grant), 32'd0);
            if (slave_done || master_done) begin
                if (sbQueue.size() == 0) begin
                    checkOutput("unexpectedDone", 32'd1, 32'd0);
                end else begin
                    e = sbQueue.pop_front();
                    checkOutput("donePort", {slave_done, master_done}, e.port ? 32'd1 : 32'd2);
                    if (!e.we) checkOutput("rdata", e.port ? master_rdata : slave_rdata, e.rdata);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   waited;
        int   doneCount;
        int   lastDone;
        logic expOrder [6];

`ifdef ARB_MASTER_PRIORITY_EN
        expOrder = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
`else
        expOrder = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
        reset = 1'b1;
        slave_req = 0; slave_we = 0; slave_addr = 0; slave_be = 0; slave_wdata = 0;
        master_req = 0; master_we = 0; master_addr = 0; master_be = 0; master_wdata = 0;
        sramModel[18'h3FFFF] = 16'h1234;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("resetCtrl", {CE_n, OE_n, WE_n, LB_n, UB_n, dout_oe}, 32'b111110);
        checkOutput("resetGrantDone", {slave_grant, master_grant, slave_done, master_done}, 32'd0);
        checkOutput("resetAddrData", {mem_addr[15:0], dout_o}, 32'd0);
        checkOutput("resetRdata", {slave_rdata, master_rdata}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Slave full-word write: pin sequence during the access
        applyStimulus(1'b0, 1'b1, 18'h00010, 2'b11, 16'hA55A, 16'h0000);
        for (int i = 0; i < ACCESS_CYCLES; i++) begin
            @(negedge clk);
            checkOutput("wrGrant", {slave_grant, master_grant}, 32'b10);
            checkOutput("wrCtrl", {CE_n, OE_n, WE_n, dout_oe, LB_n, UB_n},
                        {26'd0, 1'b0, 1'b1, (i == ACCESS_CYCLES - 1), 1'b1, 2'b00});
            checkOutput("wrAddr", 32'(mem_addr), 32'h00010);
            checkOutput("wrData", 32'(dout_o), 32'hA55A);
        end
        waitDone(1'b0, waited);
        checkOutput("wrDoneLatency", waited, 32'd1);
        checkOutput("doneCtrl", {CE_n, OE_n, WE_n, dout_oe, slave_grant}, 32'b11101);
        @(negedge clk);
        checkOutput("grantDropped", {slave_grant, master_grant}, 32'd0);

        // Master lower-byte read of the top address
        applyStimulus(1'b1, 1'b0, 18'h3FFFF, 2'b01, 16'h0000, 16'h1234);
        for (int i = 0; i < ACCESS_CYCLES; i++) begin
            @(negedge clk);
            checkOutput("rdGrant", {slave_grant, master_grant}, 32'b01);
            checkOutput("rdCtrl", {CE_n, OE_n, WE_n, dout_oe, LB_n, UB_n}, 32'b001001);
            checkOutput("rdAddr", 32'(mem_addr), 32'h3FFFF);
        end
        waitDone(1'b1, waited);
        checkOutput("rdDoneLatency", waited, 32'd1);
        @(negedge clk);
        checkOutput("rdataHeld", 32'(master_rdata), 32'h1234);

        // Both ports saturated for six accesses
        for (int k = 0; k < 6; k++) begin
            sbQueue.push_back('{port: expOrder[k], we: 1'b0, rdata: expOrder[k] ? 16'h1234 : 16'hA55A});
        end
        slave_we = 0; slave_addr = 18'h00010; slave_be = 2'b11;
        master_we = 0; master_addr = 18'h3FFFF; master_be = 2'b11;
        slave_req = 1; master_req = 1;
        doneCount = 0;
        lastDone  = 0;
        for (int cyc = 1; cyc <= 100 && doneCount < 6; cyc++) begin
            @(negedge clk);
            if (slave_done || master_done) begin
                doneCount++;
                if (doneCount > 1) checkOutput("contentionGap", cyc - lastDone, ACCESS_CYCLES + 2);
                lastDone = cyc;
                if (doneCount == 6) begin
                    slave_req  = 0;
                    master_req = 0;
                end
            end
        end
        checkOutput("contentionDones", doneCount, 32'd6);
        repeat (2) @(negedge clk);
        checkOutput("contentionIdle", {slave_grant, master_grant}, 32'd0);

        // Master lower-byte write, then slave read-back of the merged word
        applyStimulus(1'b1, 1'b1, 18'h00010, 2'b01, 16'h00FF, 16'h0000);
        waitDone(1'b1, waited);
        checkOutput("beWrLatency", waited, ACCESS_CYCLES + 1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 18'h00010, 2'b11, 16'h0000, 16'hA5FF);
        waitDone(1'b0, waited);
        checkOutput("beRdLatency", waited, ACCESS_CYCLES + 1);
        @(negedge clk);

        // Slave drops its request one clock after grant; access still completes
        applyStimulus(1'b0, 1'b1, 18'h00030, 2'b11, 16'h1357, 16'h0000);
        @(negedge clk);
        slave_req = 1'b0;
        waitDone(1'b0, waited);
        checkOutput("dropLatency", waited, ACCESS_CYCLES);
        @(negedge clk);

        // Slave owned last access, so the master wins the next contention
        applyStimulus(1'b1, 1'b0, 18'h00030, 2'b11, 16'h0000, 16'h1357);
        applyStimulus(1'b0, 1'b0, 18'h3FFFF, 2'b11, 16'h0000, 16'h1234);
        waitDone(1'b1, waited);
        checkOutput("afterDropMasterLatency", waited, ACCESS_CYCLES + 1);
        waitDone(1'b0, waited);
        checkOutput("afterDropSlaveLatency", waited, ACCESS_CYCLES + 2);
        @(negedge clk);

        // Reset at ACCESS count 1 of a write; the held request restarts
        applyStimulus(1'b0, 1'b1, 18'h00020, 2'b11, 16'hBEEF, 16'h0000);
        repeat (2) @(negedge clk);
        checkOutput("preResetCtrl", {CE_n, WE_n, slave_grant}, 32'b001);
        #1 reset = 1'b1;
        #1;
        checkOutput("midResetCtrl", {CE_n, OE_n, WE_n, LB_n, UB_n, dout_oe}, 32'b111110);
        checkOutput("midResetGrant", {slave_grant, master_grant, slave_done}, 32'd0);
        checkOutput("midResetAddr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        waitDone(1'b0, waited);
        checkOutput("restartLatency", waited, ACCESS_CYCLES + 1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 18'h00020, 2'b11, 16'h0000, 16'hBEEF);
        waitDone(1'b0, waited);
        checkOutput("restartReadLatency", waited, ACCESS_CYCLES + 1);

        repeat (3) @(negedge clk);
        checkOutput("scoreboardEmpty", sbQueue.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-port access arbiter and sequencer for the single asynchronous 16-bit external SRAM. It shares the SRAM between the CPU-side SPI slave path ("slave" port) and the Si4463 wireless path ("master" port). For each granted request it runs one complete SRAM read or write cycle and drives all SRAM pins. It sits between the FIFO address logic of both paths and the board SRAM pins.

## Interface
Parameters:
- ACCESS_CYCLES, 4: clocks CE_n is held low per access; legal range 2..15.
- MAX_BURST, 8: consecutive master grants allowed before a pending slave request is forced through (priority mode only); legal range 1..255.

Ports (prefix p = slave_ / master_, one identical set per requester):
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- p_req  in  1  access request; level, held until p_done.
- p_we  in  1  1 = write, 0 = read; stable while p_req=1.
- p_addr  in  18  word address; stable while p_req=1.
- p_be  in  2  byte enables [1]=upper, [0]=lower, active-high.
- p_wdata  in  16  write data; stable while p_req=1.
- p_grant  out  1  high for the whole access owned by this port.
- p_done  out  1  one-cycle pulse at end of access.
- p_rdata  out  16  read data; valid when p_done=1, held until the next read by the same port.
- mem_addr  out  18  SRAM address.
- dout_o  out  16  write data toward the pad.
- dout_i  in  16  data from the pad.
- dout_oe  out  1  pad output enable; the top level builds the Dout tristate from dout_o, dout_i and dout_oe.
- CE_n, OE_n, WE_n, LB_n, UB_n  out  1 each  SRAM controls, active-low.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay.
  - One request: latch that port's addr/we/be/wdata, set its grant, go to ACCESS.
  - Both requesting: arbitration rule below.
- ACCESS lasts ACCESS_CYCLES clocks; a 4-bit cycle counter runs 0..ACCESS_CYCLES-1.
  - CE_n=0 throughout. mem_addr holds the latched address. LB_n/UB_n = ~be.
  - Read: OE_n=0 and dout_oe=0 throughout. dout_i is registered into p_rdata on the last ACCESS cycle.
  - Write: dout_oe=1 and dout_o=wdata throughout. WE_n=0 on counts 0..ACCESS_CYCLES-2 and 1 on the last count, giving data-hold margin.
- DONE, one clock:
  - p_done=1 for the owner. CE_n, OE_n and WE_n all 1. dout_oe=0.
  - Grant drops at the exit of DONE. Return to IDLE.
- Arbitration, default (round-robin):
  - A last_owner bit records the previous owner; reset value = master.
  - When both ports request, the port that is not last_owner wins.
- Deasserting p_req mid-access has no effect: the access completes and p_done still pulses.
- A request that is still high after p_done is treated as a new request in the next IDLE cycle.
- Address and data are latched at the grant, so requester changes during ACCESS are ignored.
- Reset, asynchronous and effective even mid-access:
  - State=IDLE, grants=0, done=0, rdata=0.
  - CE_n=OE_n=WE_n=LB_n=UB_n=1, dout_oe=0, mem_addr=0, dout_o=0.
  - last_owner=master, burst counter=0.
  - An interrupted access is lost; no p_done is issued.

## Timing
- Request high at IDLE edge N → grant high from N+1; ACCESS occupies N+1..N+ACCESS_CYCLES; p_done at N+ACCESS_CYCLES+1.
- Request-to-done latency = ACCESS_CYCLES+1 clocks.
- Sustained throughput = one access per ACCESS_CYCLES+2 clocks.
- Both ports saturated: grants strictly alternate (round-robin mode).
- Grants are one-hot or zero, never both high.
- All SRAM outputs are registered; no combinational path from p_* inputs to SRAM pins.

## Configuration
- ARB_MASTER_PRIORITY_EN defined:
  - On contention the master port wins, to protect radio RX/TX timing.
  - An 8-bit burst counter counts consecutive master grants that occurred while a slave request was pending.
  - When the counter reaches MAX_BURST, the slave is granted next and the counter clears.
  - The counter also clears on any slave grant and on any IDLE cycle where the slave is not requesting.
- Undefined: round-robin as in Operation; no burst counter is synthesized.

## Test plan
- Slave write addr 0x00010, data 0xA55A, be=2'b11 → slave_grant for 4 clocks; WE_n low for 3 clocks then high for 1; dout_oe=1; slave_done 5 clocks after req.
- Master read addr 0x3FFFF, model drives 0x1234, be=2'b01 → OE_n=0, UB_n=1, LB_n=0; master_rdata=0x1234 with master_done.
- Both requesting continuously for 6 accesses (default build) → grant order slave, master, slave, master, slave, master; grants never overlap; no dead cycles beyond DONE/IDLE.
- ARB_MASTER_PRIORITY_EN, MAX_BURST=3, both saturated → pattern M, M, M, S repeats.
- Reset asserted at ACCESS count 1 of a write → WE_n, CE_n and all grants high/low to idle values in the same cycle; no done pulse. After release, a held request restarts a full access.
- slave_req dropped one clock after grant → access completes and slave_done pulses. A subsequent master-only request is served with last_owner=slave.
